// File: rtl/turn_signal_sequencer.sv
// turn_signal_sequencer
//   Rear-lamp sequencer. It drives LAMPS lamps per side and supports:
//   - a chasing left or right turn pattern,
//   - a hazard flash on both sides,
//   - an optional brake overlay.
//   A built-in prescaler produces the animation tick. A mode/phase state
//   machine advances only on tick. The lamp outputs are registered every clock.
//
// Optional feature:
//   TS_BRAKE_EN - when defined, brake=1 lights every lamp of a non-signalling
//                 side steadily. The hazard pattern overrides brake.
//
// Parameters:
//   LAMPS     lamps per side (1..8)
//   TICK_DIV  clocks per animation tick (>=1)
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset, clears all state
//   left_req     level, left turn requested
//   right_req    level, right turn requested
//   hazard_req   level, hazard requested
//   brake        level, brake pedal (only used with TS_BRAKE_EN)
//   lamps_left   left lamps, bit 0 innermost
//   lamps_right  right lamps, bit 0 innermost
//   mode         00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD
//   phase        sweep position
//   tick         one-clock animation strobe
module turn_signal_sequencer #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 2500000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         left_req,
  input  logic                         right_req,
  input  logic                         hazard_req,
  input  logic                         brake,
  output logic [LAMPS-1:0]             lamps_left,
  output logic [LAMPS-1:0]             lamps_right,
  output logic [1:0]                   mode,
  output logic [$clog2(LAMPS+1)-1:0]   phase,
  output logic                         tick
);

  localparam int PW = $clog2(LAMPS + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    M_IDLE   = 2'b00,
    M_LEFT   = 2'b01,
    M_RIGHT  = 2'b10,
    M_HAZARD = 2'b11
  } mode_t;

  logic [CW-1:0]    count_p0;
  mode_t            mode_q, mode_d, req_mode;
  logic [PW-1:0]    phase_q, phase_d;
  logic [LAMPS-1:0] left_d, right_d;
  logic [LAMPS-1:0] lamps_left_p1, lamps_right_p1;

  // Thermometer code: bits [p-1:0] are set.
  function automatic logic [LAMPS-1:0] thermo(input logic [PW-1:0] p);
    logic [LAMPS-1:0] t;
    t = '0;
    for (int i = 0; i < LAMPS; i++) begin
      t[i] = (i < int'(p));
    end
    return t;
  endfunction

  // ---- stage p0: tick prescaler ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_p0 <= '0;
    end else if (count_p0 == CW'(TICK_DIV - 1)) begin
      count_p0 <= '0;
    end else begin
      count_p0 <= count_p0 + 1'b1;
    end
  end

  // When TICK_DIV=1 the count is pinned at 0, so tick stays high.
  assign tick = (count_p0 == CW'(TICK_DIV - 1));

  // Request priority. Both turn requests together behave as a hazard.
  always_comb begin
    req_mode = M_IDLE;
    if (hazard_req || (left_req && right_req)) begin
      req_mode = M_HAZARD;
    end else if (left_req) begin
      req_mode = M_LEFT;
    end else if (right_req) begin
      req_mode = M_RIGHT;
    end
  end

  // ---- mode/phase state machine, advances on tick ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q  <= M_IDLE;
      phase_q <= '0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    if (tick) begin
      if (mode_q != M_HAZARD && req_mode == M_HAZARD) begin
        // A hazard request preempts a turn sweep at any phase.
        mode_d  = M_HAZARD;
        phase_d = PW'(1);
      end else if (phase_q == '0) begin
        // Phase 0 is the only point where a new mode is accepted.
        mode_d  = req_mode;
        phase_d = (req_mode == M_IDLE) ? '0 : PW'(1);
      end else if ((mode_q == M_LEFT || mode_q == M_RIGHT) && phase_q == PW'(LAMPS)) begin
        phase_d = '0;
      end else if (mode_q == M_HAZARD && phase_q == PW'(1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  assign mode  = mode_q;
  assign phase = phase_q;

  // Lamp decode from the current mode, phase and brake.
  always_comb begin
    left_d  = '0;
    right_d = '0;
    case (mode_q)
      M_LEFT:   left_d  = thermo(phase_q);
      M_RIGHT:  right_d = thermo(phase_q);
      M_HAZARD: begin
        if (phase_q == PW'(1)) begin
          left_d  = '1;
          right_d = '1;
        end
      end
      default: ;
    endcase
`ifdef TS_BRAKE_EN
    // Brake lights the non-signalling side(s). Hazard is left untouched.
    if (brake) begin
      case (mode_q)
        M_IDLE: begin
          left_d  = '1;
          right_d = '1;
        end
        M_LEFT:  right_d = '1;
        M_RIGHT: left_d  = '1;
        default: ;
      endcase
    end
`endif
  end

`ifndef TS_BRAKE_EN
  logic brake_unused;
  assign brake_unused = brake;
`endif

  // ---- stage p1: registered lamp outputs, updated every clock ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lamps_left_p1  <= '0;
      lamps_right_p1 <= '0;
    end else begin
      lamps_left_p1  <= left_d;
      lamps_right_p1 <= right_d;
    end
  end

  assign lamps_left  = lamps_left_p1;
  assign lamps_right = lamps_right_p1;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
module tb_turn_signal_sequencer;

  localparam int L  = 3;
  localparam int TD = 4;
  localparam int PW = $clog2(L + 1);
  localparam int EW = 1 + 2 + PW + 2 * L;

  logic          clock;
  logic          reset;
  logic          left_req, right_req, hazard_req, brake;
  logic [L-1:0]  lamps_left, lamps_right;
  logic [1:0]    mode;
  logic [PW-1:0] phase;
  logic          tick;

  turn_signal_sequencer #(.LAMPS(L), .TICK_DIV(TD)) dut (
    .clock       (clock),
    .reset       (reset),
    .left_req    (left_req),
    .right_req   (right_req),
    .hazard_req  (hazard_req),
    .brake       (brake),
    .lamps_left  (lamps_left),
    .lamps_right (lamps_right),
    .mode        (mode),
    .phase       (phase),
    .tick        (tick)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sb[$];

  // Reference model state. Mode codes: 0 idle, 1 left, 2 right, 3 hazard.
  int m_cnt, m_mode, m_ph, m_ll, m_lr;

  function automatic logic [EW-1:0] pack_exp();
    logic       t;
    logic [1:0] md;
    logic [PW-1:0] ph;
    logic [L-1:0] ll, lr;
    t  = (m_cnt == TD - 1);
    md = 2'(m_mode);
    ph = PW'(m_ph);
    ll = L'(m_ll);
    lr = L'(m_lr);
    return {t, md, ph, ll, lr};
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_mode = 0; m_ph = 0; m_ll = 0; m_lr = 0;
  endtask

  // Behavioural model, evaluated at each rising edge from pre-edge values.
  always @(posedge clock) begin
    int all_on, th, nl, nr, req;
    if (reset) begin
      model_clear();
    end else begin
      all_on = (1 << L) - 1;
      th     = (1 << m_ph) - 1;
      nl = 0; nr = 0;
      if (m_mode == 1) nl = th;
      if (m_mode == 2) nr = th;
      if (m_mode == 3 && m_ph == 1) begin nl = all_on; nr = all_on; end
`ifdef TS_BRAKE_EN
      if (brake && m_mode != 3) begin
        if (m_mode != 1) nl = all_on;
        if (m_mode != 2) nr = all_on;
      end
`endif
      if (m_cnt == TD - 1) begin
        if (hazard_req || (left_req && right_req)) req = 3;
        else if (left_req) req = 1;
        else if (right_req) req = 2;
        else req = 0;
        if (m_mode != 3 && req == 3) begin
          m_mode = 3; m_ph = 1;
        end else if (m_ph == 0) begin
          m_mode = req; m_ph = (req == 0) ? 0 : 1;
        end else if ((m_mode == 1 || m_mode == 2) && m_ph == L) begin
          m_ph = 0;
        end else if (m_mode == 3 && m_ph == 1) begin
          m_ph = 0;
        end else begin
          m_ph = m_ph + 1;
        end
      end
      m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
      m_ll = nl;
      m_lr = nr;
    end
    sb.push_back(pack_exp());
  end

  // Monitor: every falling edge the DUT presents a new output word.
  always @(negedge clock) begin
    logic [EW-1:0] exp_v, got_v;
    got_v = {tick, mode, phase, lamps_left, lamps_right};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t got=%b required=an expected entry", $time, got_v);
    end else begin
      exp_v = sb.pop_front();
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got tick=%b mode=%b phase=%0d L=%b R=%b required tick=%b mode=%b phase=%0d L=%b R=%b",
                 $time, got_v[EW-1], got_v[EW-2 -: 2], got_v[2*L +: PW], got_v[L +: L], got_v[0 +: L],
                 exp_v[EW-1], exp_v[EW-2 -: 2], exp_v[2*L +: PW], exp_v[L +: L], exp_v[0 +: L]);
      end
    end
  end

  task automatic drive(input logic l, input logic r, input logic h, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
      left_req = l; right_req = r; hazard_req = h; brake = b;
    end
  endtask

  // Asserts reset between clock edges, holds it for two edges, releases mid-cycle.
  task automatic pulse_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    model_clear();
    sb.delete();
    sb.push_back(pack_exp());
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  task automatic wait_state(input int md, input int ph);
    int k;
    k = 0;
    while (!(m_mode == md && m_ph == ph) && k < 40) begin
      @(posedge clock);
      #2;
      k++;
    end
    if (k >= 40) begin
      checks++;
      errors++;
      $display("FAIL wait_state t=%0t got mode=%0d phase=%0d required mode=%0d phase=%0d", $time, m_mode, m_ph, md, ph);
    end
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    left_req = 1'b1; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    // Left held from reset.
    drive(1, 0, 0, 0, 30);
    // Hazard asserted at phase 2 of a left sweep, then released.
    wait_state(1, 2);
    drive(1, 0, 1, 0, 13);
    drive(1, 0, 0, 0, 16);
    // Left released while phase 1.
    wait_state(1, 1);
    drive(0, 0, 0, 0, 20);
    // Left and right together from idle.
    drive(1, 1, 0, 0, 17);
    drive(0, 0, 0, 0, 10);
    // Brake with a right sweep, then idle with brake.
    drive(0, 1, 0, 1, 21);
    drive(0, 0, 0, 1, 12);
    drive(0, 0, 0, 0, 6);
    // Reset in the middle of a left sweep.
    drive(1, 0, 0, 0, 2);
    wait_state(1, 2);
    pulse_reset();
    drive(1, 0, 0, 0, 20);
    // Randomised segments.
    for (int s = 0; s < 80; s++) begin
      logic l, r, h, b;
      int n;
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 5) == 0);
      b = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 24);
      if ($urandom_range(0, 19) == 0) pulse_reset();
      drive(l, r, h, b, n);
    end
    drive(0, 0, 0, 0, 12);
    repeat (2) @(posedge clock);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_signal_sequencer.md
# turn_signal_sequencer

Parametrised rear-lamp sequencer for the car lighting design: drives N lamps per side with sequential (chasing) left/right turn patterns, a both-side hazard flash, and an optional brake overlay. Contains its own tick prescaler and mode/phase state machine. It replaces the fixed three-lamp divider/counter/state-register/output chain with one reusable block instantiated between the switch/key inputs and the LEDR/HEX outputs.

## Interface
- LAMPS, default 3: lamps per side, legal 1..8
- TICK_DIV, default 2500000: clocks per animation tick, legal ≥1
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- left_req  input  1  level, left turn requested
- right_req  input  1  level, right turn requested
- hazard_req  input  1  level, hazard requested
- brake  input  1  level, brake pedal (used only with TS_BRAKE_EN)
- lamps_left  output  LAMPS  left lamps, bit 0 innermost
- lamps_right  output  LAMPS  right lamps, bit 0 innermost
- mode  output  2  00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD
- phase  output  clog2(LAMPS+1)  sweep position
- tick  output  1  one-clock animation strobe

## Operation
- Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 while count==TICK_DIV-1 (combinational decode). TICK_DIV=1: tick constantly high.
- Requested mode R (priority): hazard_req, or left_req&right_req → HAZARD; else left_req → LEFT; else right_req → RIGHT; else IDLE.
- mode/phase change only on edges where tick=1:
  - mode≠HAZARD and R==HAZARD: mode←HAZARD, phase←1 (preempts at any phase).
  - phase==0 (includes IDLE): mode←R; phase←(R==IDLE)?0:1.
  - LEFT/RIGHT, phase==LAMPS: phase←0, mode held.
  - HAZARD, phase==1: phase←0, mode held.
  - otherwise: phase←phase+1.
- Consequence: releasing a turn request mid-sweep completes the sweep and the off step, then goes IDLE; switching LEFT↔RIGHT takes effect only at phase 0.
- Lamp decode, phase p: LEFT → lamps_left = thermometer of p (bits [p-1:0] on), lamps_right=0; RIGHT mirrored; HAZARD → both sides all-ones when p==1, all-zero when p==0; IDLE → both 0.
- Lamp outputs are registered every clock (not only on tick) from current mode, phase, brake.

## Timing
- Reset: prescaler 0, mode IDLE, phase 0, lamps_left/lamps_right 0, tick 0 (count 0 ≠ TICK_DIV-1 unless TICK_DIV=1); all take effect immediately on reset assertion, independent of clock.
- First tick: the TICK_DIV-th cycle after reset release.
- mode/phase update at edge closing the tick cycle; lamps reflect them one clock later.
- brake change visible on lamps one clock later.
- Turn sweep period: (LAMPS+1)·TICK_DIV clocks; hazard period: 2·TICK_DIV.
- Requests sampled only at tick edges; pulses shorter than TICK_DIV may be missed by design.

## Configuration
- TS_BRAKE_EN defined: brake=1 forces every lamp of a non-signalling side on steady (both sides in IDLE, opposite side in LEFT/RIGHT); HAZARD pattern overrides brake; turn side keeps its sweep.
- TS_BRAKE_EN undefined: brake input unused; lamp decode as above only.

## Test plan
(LAMPS=3, TICK_DIV=4)
- left_req held from reset → lamps_left steps 001,011,111,000,001… each 4 clocks, first 001 at clock 5; lamps_right stays 000; mode=01.
- left_req held, hazard_req asserted at phase 2 → at next tick mode=11; both sides 111 then 000 alternating every 4 clocks; on release, ends at next phase 0 in IDLE or R.
- left_req released while phase=1 → 111 and 000 still shown, then mode=00, lamps 000.
- left_req and right_req together from IDLE → mode=11, hazard flash identical to hazard_req.
- TS_BRAKE_EN on: right_req held, brake=1 → lamps_left=111 steady, right sweeps; IDLE + brake → both 111 one clock after brake; macro off → brake has no effect.
- reset asserted mid-sweep (phase 2, between clock edges) → lamps, mode, phase, tick cleared immediately; after release, sequence restarts with first tick at clock 4.
